// File: rtl/lzc_pkg.sv
// Shared sizing helpers for the pipelined leading-zero counter.
// Nibble-based grouping: operands are split into GROUP_W-bit groups.
package lzc_pkg;

    localparam int GROUP_W = 4;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int n_groups(input int width);
        return (width + GROUP_W - 1) / GROUP_W;
    endfunction

endpackage

// File: rtl/lzc_pipe_if.sv
// Operand/result handshake bundle for lzc_pipe; out_norm exists only with LZC_NORM_EN.
// slave = the counter itself, master = the producer/consumer pair around it.
interface lzc_pipe_if #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
);
    import lzc_pkg::*;

    localparam int CNT_W = cnt_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_cnt;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] out_norm;
`endif

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_cnt, out_zero, out_tag
`ifdef LZC_NORM_EN
        , output out_norm
`endif
    );

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_cnt, out_zero, out_tag
`ifdef LZC_NORM_EN
        , input out_norm
`endif
    );

endinterface

// File: rtl/lzc_nibble.sv
// Leading-zero count of one 4-bit group plus all-zero flag.
// Latency: combinational. Backpressure: none (pure logic).
// Count is 0 when the group is all zero; the flag carries that case.
module lzc_nibble (
    input  logic [3:0] nib_i,
    output logic [1:0] cnt_o,
    output logic       zero_o
);

    always_comb begin
        cnt_o  = 2'd0;
        zero_o = 1'b0;
        casez (nib_i)
            4'b1???: cnt_o = 2'd0;
            4'b01??: cnt_o = 2'd1;
            4'b001?: cnt_o = 2'd2;
            4'b0001: cnt_o = 2'd3;
            default: zero_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lzc_pipe.sv
// Two-stage pipelined leading-zero counter with tag sideband; LZC_NORM_EN adds out_norm.
// Latency: 2 cycles accept-to-out_valid, 1 result/cycle.
// Backpressure: stages advance when downstream empties; in_ready = s1_adv & ~flush (comb from out_ready).
module lzc_pipe #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    lzc_pipe_if.slave io
);
    import lzc_pkg::*;

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int NG    = n_groups(WIDTH);
    localparam int PAD_W = NG * GROUP_W;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, in_fire, s2_load;

    logic [NG-1:0][1:0] nib_cnt;
    logic [NG-1:0]      nib_zero;
    logic [NG-1:0][1:0] s1_cnt_q, s1_cnt_d;
    logic [NG-1:0]      s1_zero_q, s1_zero_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;

    logic [CNT_W-1:0]   enc_cnt;
    logic               enc_found;
    logic [CNT_W-1:0]   s2_cnt_q, s2_cnt_d;
    logic               s2_zero_q, s2_zero_d;
    logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

    // Pad with 1s at the LSB end so a partial last nibble never counts padding as zeros.
    logic [PAD_W-1:0] padded;
    if (PAD_W > WIDTH) begin : g_pad
        assign padded = {io.in_data, {(PAD_W - WIDTH){1'b1}}};
    end else begin : g_nopad
        assign padded = io.in_data;
    end

    for (genvar k = 0; k < NG; k++) begin : g_nib
        lzc_nibble u_nib (
            .nib_i  (padded[PAD_W-1-GROUP_W*k -: GROUP_W]),
            .cnt_o  (nib_cnt[k]),
            .zero_o (nib_zero[k])
        );
    end

    assign s2_adv      = ~s2_valid_q | io.out_ready;
    assign s1_adv      = ~s1_valid_q | s2_adv;
    assign io.in_ready = s1_adv & ~flush;
    assign in_fire     = io.in_valid & io.in_ready;
    assign s2_load     = s2_adv & s1_valid_q & ~flush;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cnt_d   = s1_cnt_q;
        s1_zero_d  = s1_zero_q;
        s1_tag_d   = s1_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                s1_cnt_d  = nib_cnt;
                s1_zero_d = nib_zero;
                s1_tag_d  = io.in_tag;
            end
        end
    end

    // Nibble 0 is the most significant; padding 1s make an all-zero operand land on WIDTH.
    always_comb begin
        enc_cnt   = CNT_W'(WIDTH);
        enc_found = 1'b0;
        for (int k = 0; k < NG; k++) begin
            if (!enc_found && !s1_zero_q[k]) begin
                enc_found = 1'b1;
                enc_cnt   = CNT_W'(GROUP_W * k) + CNT_W'(s1_cnt_q[k]);
            end
        end
    end

    always_comb begin
        s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
        s2_cnt_d   = s2_load ? enc_cnt : s2_cnt_q;
        s2_zero_d  = s2_load ? (enc_cnt == CNT_W'(WIDTH)) : s2_zero_q;
        s2_tag_d   = s2_load ? s1_tag_q : s2_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_zero_q  <= s1_zero_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [WIDTH-1:0] s2_norm_q, s2_norm_d;

    assign s1_data_d = (in_fire && !flush) ? io.in_data : s1_data_q;
    // Shift by WIDTH yields zero, which is exactly the all-zero operand result.
    assign s2_norm_d = s2_load ? (s1_data_q << enc_cnt) : s2_norm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q <= '0;
            s2_norm_q <= '0;
        end else begin
            s1_data_q <= s1_data_d;
            s2_norm_q <= s2_norm_d;
        end
    end

    assign io.out_norm = s2_norm_q;
`endif

    assign io.out_valid = s2_valid_q;
    assign io.out_cnt   = s2_cnt_q;
    assign io.out_zero  = s2_zero_q;
    assign io.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzc_pipe.sv
// Drives a WIDTH=24 and a WIDTH=10 lzc_pipe with identical handshake stimulus; out_norm
// is checked when LZC_NORM_EN is defined.
module tb_lzc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    lzc_pipe_if #(.WIDTH(24), .TAG_W(4)) b24 ();
    lzc_pipe_if #(.WIDTH(10), .TAG_W(4)) b10 ();

    assign b24.in_valid  = in_valid;
    assign b24.in_data   = in_data;
    assign b24.in_tag    = in_tag;
    assign b24.out_ready = out_ready;
    assign b10.in_valid  = in_valid;
    assign b10.in_data   = in_data[9:0];
    assign b10.in_tag    = in_tag;
    assign b10.out_ready = out_ready;

    lzc_pipe #(.WIDTH(24), .TAG_W(4)) u24 (.clk(clk), .rst_n(rst_n), .flush(flush), .io(b24.slave));
    lzc_pipe #(.WIDTH(10), .TAG_W(4)) u10 (.clk(clk), .rst_n(rst_n), .flush(flush), .io(b10.slave));

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: scan from the MSB for the first 1.
    function automatic int ref_lzc(input logic [23:0] d, input int w);
        for (int i = w - 1; i >= 0; i--)
            if (d[i]) return w - 1 - i;
        return w;
    endfunction

    function automatic logic [23:0] ref_norm(input logic [23:0] d, input int w);
        logic [24:0] m;
        logic [23:0] dm;
        m  = (25'd1 << w) - 25'd1;
        dm = d & m[23:0];
        return (dm << ref_lzc(dm, w)) & m[23:0];
    endfunction

    typedef struct {
        logic [23:0] d;
        logic [3:0]  t;
        int          acc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [23:0] d;
        logic [3:0]  t;
        int          c24;
        logic        z24;
        logic [23:0] n24;
        int          c10;
        logic        z10;
        logic [9:0]  n10;
    } vec_t;
    vec_t tbl[9];

    bit          stalled_prev = 0;
    logic [31:0] h_cnt24, h_cnt10, h_tag24, h_zero24, h_zero10, h_norm24, h_norm10;
    bit          acc;

    // One clock of stimulus plus scoreboard update; inputs change at negedge only.
    task automatic step(input bit v, input logic [23:0] d, input logic [3:0] t,
                        input bit rdy, input bit fl, output bit accepted);
        bit   exp_rdy, exp_vld;
        exp_t e;
        @(negedge clk);
        cyc++;
        in_valid = v; in_data = d; in_tag = t; out_ready = rdy; flush = fl;
        #1;
        if (stalled_prev) begin
            chk("hold_cnt24", 32'(b24.out_cnt), h_cnt24);
            chk("hold_cnt10", 32'(b10.out_cnt), h_cnt10);
            chk("hold_zero24", 32'(b24.out_zero), h_zero24);
            chk("hold_zero10", 32'(b10.out_zero), h_zero10);
            chk("hold_tag24", 32'(b24.out_tag), h_tag24);
`ifdef LZC_NORM_EN
            chk("hold_norm24", 32'(b24.out_norm), h_norm24);
            chk("hold_norm10", 32'(b10.out_norm), h_norm10);
`endif
        end
        exp_rdy = fl ? 1'b0 : !(q.size() == 2 && !rdy);
        exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
        chk("in_ready24", 32'(b24.in_ready), 32'(exp_rdy));
        chk("in_ready10", 32'(b10.in_ready), 32'(exp_rdy));
        chk("out_valid24", 32'(b24.out_valid), 32'(exp_vld));
        chk("out_valid10", 32'(b10.out_valid), 32'(exp_vld));
        accepted = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (exp_vld && rdy) begin
                e = q.pop_front();
                chk("cnt24", 32'(b24.out_cnt), ref_lzc(e.d, 24));
                chk("zero24", 32'(b24.out_zero), 32'(e.d == 24'd0));
                chk("tag24", 32'(b24.out_tag), 32'(e.t));
                chk("cnt10", 32'(b10.out_cnt), ref_lzc(e.d & 24'h3FF, 10));
                chk("zero10", 32'(b10.out_zero), 32'(e.d[9:0] == 10'd0));
                chk("tag10", 32'(b10.out_tag), 32'(e.t));
`ifdef LZC_NORM_EN
                chk("norm24", 32'(b24.out_norm), 32'(ref_norm(e.d, 24)));
                chk("norm10", 32'(b10.out_norm), 32'(ref_norm(e.d, 10)));
`endif
            end
            accepted = v && exp_rdy;
            if (accepted) q.push_back('{d, t, cyc});
        end
        stalled_prev = exp_vld && !rdy && !fl;
        h_cnt24 = 32'(b24.out_cnt);   h_cnt10 = 32'(b10.out_cnt);
        h_zero24 = 32'(b24.out_zero); h_zero10 = 32'(b10.out_zero);
        h_tag24 = 32'(b24.out_tag);
`ifdef LZC_NORM_EN
        h_norm24 = 32'(b24.out_norm); h_norm10 = 32'(b10.out_norm);
`else
        h_norm24 = '0; h_norm10 = '0;
`endif
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_vld24"}, 32'(b24.out_valid), 0);
        chk({nm, "_vld10"}, 32'(b10.out_valid), 0);
        chk({nm, "_cnt24"}, 32'(b24.out_cnt), 0);
        chk({nm, "_cnt10"}, 32'(b10.out_cnt), 0);
        chk({nm, "_zero24"}, 32'(b24.out_zero), 0);
        chk({nm, "_tag24"}, 32'(b24.out_tag), 0);
        chk({nm, "_tag10"}, 32'(b10.out_tag), 0);
`ifdef LZC_NORM_EN
        chk({nm, "_norm24"}, 32'(b24.out_norm), 0);
        chk({nm, "_norm10"}, 32'(b10.out_norm), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [23:0] one;
        logic [23:0] r;
        int          guard;
        int          p;

        tbl[0] = '{24'h001234, 4'h3, 11, 1'b0, 24'h91A000, 0,  1'b0, 10'h234};
        tbl[1] = '{24'h000000, 4'h5, 24, 1'b1, 24'h000000, 10, 1'b1, 10'h000};
        tbl[2] = '{24'h800000, 4'h6, 0,  1'b0, 24'h800000, 10, 1'b1, 10'h000};
        tbl[3] = '{24'h000001, 4'h7, 23, 1'b0, 24'h800000, 9,  1'b0, 10'h200};
        tbl[4] = '{24'hFFFFFF, 4'h8, 0,  1'b0, 24'hFFFFFF, 0,  1'b0, 10'h3FF};
        tbl[5] = '{24'h000080, 4'h9, 16, 1'b0, 24'h800000, 2,  1'b0, 10'h200};
        tbl[6] = '{24'h000200, 4'hA, 14, 1'b0, 24'h800000, 0,  1'b0, 10'h200};
        tbl[7] = '{24'h0003FE, 4'hB, 14, 1'b0, 24'hFF8000, 0,  1'b0, 10'h3FE};
        tbl[8] = '{24'h000040, 4'hC, 17, 1'b0, 24'h800000, 3,  1'b0, 10'h200};

        // Reset values
        #1;
        chk_reset_outputs("rst");
        chk("rst_in_ready", 32'(b24.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: single operand, fixed 2-cycle latency
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = tbl[i].d; in_tag = tbl[i].t; out_ready = 1'b1;
            #1 chk("tbl_in_ready", 32'(b24.in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0; in_data = 24'h5A5A5A;
            #1 chk("tbl_early_vld", 32'(b24.out_valid), 0);
            @(negedge clk);
            #1;
            chk("tbl_vld24", 32'(b24.out_valid), 1);
            chk("tbl_vld10", 32'(b10.out_valid), 1);
            chk("tbl_cnt24", 32'(b24.out_cnt), tbl[i].c24);
            chk("tbl_zero24", 32'(b24.out_zero), 32'(tbl[i].z24));
            chk("tbl_tag24", 32'(b24.out_tag), 32'(tbl[i].t));
            chk("tbl_cnt10", 32'(b10.out_cnt), tbl[i].c10);
            chk("tbl_zero10", 32'(b10.out_zero), 32'(tbl[i].z10));
`ifdef LZC_NORM_EN
            chk("tbl_norm24", 32'(b24.out_norm), 32'(tbl[i].n24));
            chk("tbl_norm10", 32'(b10.out_norm), 32'(tbl[i].n10));
`endif
        end

        // Walking one, back to back
        one = 24'd1;
        for (int i = 0; i < 24; i++) step(1'b1, one << i, 4'(i), 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 24'hFFFFFF, 4'h0, 1'b1, 1'b0, acc);

        // Backpressure: tags 0..7 with out_ready pattern 1,0,0,...
        p = 0;
        for (int t = 0; t < 8; t++) begin
            guard = 0;
            acc = 1'b0;
            while (!acc && guard < 20) begin
                r = 24'($urandom);
                step(1'b1, r >> $urandom_range(0, 24), 4'(t), (p % 3) == 0, 1'b0, acc);
                p++;
                guard++;
            end
            if (!acc) begin
                vecs++; errs++;
                $display("FAIL bp_accept: tag %0d not accepted after %0d cycles", t, guard);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 4'h0, 1'b1, 1'b0, acc);

        // Flush with both stages full and a valid input in the same cycle
        step(1'b1, 24'h000F00, 4'h1, 1'b0, 1'b0, acc);
        step(1'b1, 24'h00000F, 4'h2, 1'b0, 1'b0, acc);
        step(1'b1, 24'h0F0000, 4'h3, 1'b0, 1'b1, acc);
        step(1'b1, 24'h003000, 4'h4, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 4'h0, 1'b1, 1'b0, acc);

        // Random traffic with random stalls and occasional flush
        for (int i = 0; i < 300; i++) begin
            r = 24'($urandom);
            if ($urandom_range(0, 7) == 0) r = 24'd0;
            else r = r >> $urandom_range(0, 24);
            step($urandom_range(0, 3) != 0, r, 4'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0, acc);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 24'h000123 << i, 4'(i + 9), 1'b0, 1'b0, acc);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst");
        q.delete();
        stalled_prev = 0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 4'h0, 1'b1, 1'b0, acc);
        step(1'b1, 24'h000456, 4'hE, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 4'h0, 1'b1, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
